riscv_fetch_ctrl: RTL and testbench
===================================

# riscv_fetch_ctrl

Multi-cycle instruction-fetch sequencer for the NPC core. It owns the architectural PC register and issues one fetch per instruction to the instruction-memory port with a valid/ready request and a valid response. It presents the fetched instruction to decode/execute and commits the next-PC value from the next-PC adder only when execute reports completion. It replaces the free-running per-cycle PC update with a handshake-driven loop, and adds halt, fault and retire tracking.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 255, fetch-response watchdog limit in cycles. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- npc_i  in  32  next PC from the next-PC adder, valid while exec_done_i is high.
- exec_done_i  in  1  execute/LSU has finished the current instruction.
- halt_i  in  1  current instruction is ebreak; sampled with exec_done_i.
- imem_req_valid_o  out  1  fetch request valid.
- imem_req_ready_i  in  1  memory accepts the request.
- imem_req_addr_o  out  32  fetch address; always equals pc_o.
- imem_resp_valid_i  in  1  fetch response valid.
- imem_resp_data_i  in  32  fetched instruction.
- imem_resp_err_i  in  1  bus error, qualified by imem_resp_valid_i.
- pc_o  out  32  architectural PC.
- inst_o  out  32  latched instruction.
- inst_valid_o  out  1  inst_o is valid for execute.
- retire_o  out  1  one-cycle pulse per retired instruction.
- instret_o  out  32  retired-instruction count; wraps at 2^32.
- halted_o  out  1  core stopped by ebreak.
- fault_o  out  1  core stopped by a fault.
- fault_cause_o  out  2  01 misaligned npc, 10 bus error, 11 timeout, 00 none.

## Operation
- FSM states: S_REQ, S_WAIT, S_EXEC, S_HALT, S_FAULT.
- Reset (any state): state=S_REQ, pc_o=RESET_PC, inst_o=0, instret_o=0, fault_cause_o=0, halted_o=0, fault_o=0, retire_o=0. imem_req_valid_o is forced to 0 while rst is high.
- S_REQ: imem_req_valid_o=1. On imem_req_ready_i, go to S_WAIT. Address and valid are held stable until ready. Responses arriving in S_REQ are ignored.
- S_WAIT: imem_req_valid_o=0.
  - On imem_resp_valid_i with no error: inst_o<=imem_resp_data_i, go to S_EXEC.
  - On imem_resp_valid_i with imem_resp_err_i: fault_cause_o<=10, go to S_FAULT.
- S_EXEC: inst_valid_o=1. The block waits for exec_done_i. When exec_done_i is high:
  - retire_o=1 and instret_o increments in every case.
  - If halt_i: go to S_HALT; pc_o is unchanged (stays at ebreak).
  - Else if npc_i[1:0]!=0: fault_cause_o<=01, go to S_FAULT; pc_o is unchanged.
  - Else: pc_o<=npc_i, go to S_REQ.
- S_HALT and S_FAULT are terminal until rst. halted_o=1 in S_HALT; fault_o=1 in S_FAULT. No requests are issued; inst_valid_o=0.
- exec_done_i and halt_i are ignored outside S_EXEC.
- The memory shares rst and drops outstanding transactions on it, so no stale response is seen after reset.

## Timing
- Minimum 3 cycles per instruction with ready=1, response one cycle after acceptance, and exec_done_i immediate:
  - cycle n: S_REQ
  - cycle n+1: S_WAIT, response arrives
  - cycle n+2: S_EXEC
  - cycle n+3: S_REQ at the new PC
- First request is visible in the first cycle after rst falls.
- The memory must not respond in the same cycle it accepts a request.
- pc_o, inst_o, instret_o and fault_cause_o are registered. imem_req_valid_o, inst_valid_o, retire_o, halted_o and fault_o decode from the current state.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - An 8+ bit wait counter clears on entry to S_WAIT and increments each S_WAIT cycle without a response.
  - On reaching TIMEOUT_CYCLES: fault_cause_o<=11, go to S_FAULT.
  - A response arriving in the same cycle the limit is reached wins.
- FETCH_TIMEOUT_EN undefined: the counter is absent, S_WAIT waits indefinitely, and cause 11 never occurs.

## Test plan
- Reset, ready=1, 1-cycle response, exec_done immediate, npc=pc+4 → fetches at 0x0, 0x4, 0x8 every 3 cycles; instret_o=3 after 9 cycles.
- Request backpressure: ready low for 4 cycles → addr stays 0x0 with valid high; S_WAIT is entered the cycle after ready rises.
- Branch: exec_done with npc_i=0x100 → next request address 0x100. With npc_i=0x102 → fault_o=1, cause 01, pc_o unchanged, no further requests.
- Bus error response → fault_o=1, cause 10, instret_o unchanged.
- halt_i with exec_done → halted_o=1, retire_o pulses once, pc_o holds the ebreak address. Asserting rst afterwards → pc_o=RESET_PC, requests resume.
- FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4, no response → fault cause 11 after 4 S_WAIT cycles. Without the macro, still waiting after 1000 cycles.

Source files
------------

// File: rtl/riscv_fetch_ctrl.sv
// Multi-cycle fetch sequencer: owns the PC, fetches, waits on execute, retires.
// Optional fetch-response watchdog enabled by defining FETCH_TIMEOUT_EN.
module riscv_fetch_ctrl #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] npc_i,
   input  logic        exec_done_i,
   input  logic        halt_i,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_req_addr_o,
   input  logic        imem_resp_valid_i,
   input  logic [31:0] imem_resp_data_i,
   input  logic        imem_resp_err_i,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic        retire_o,
   output logic [31:0] instret_o,
   output logic        halted_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o
);

   typedef enum logic [2:0] {
      S_REQ,
      S_WAIT,
      S_EXEC,
      S_HALT,
      S_FAULT
   } state_t;

   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_BUS      = 2'b10;
`ifdef FETCH_TIMEOUT_EN
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
   localparam int CLOG = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CW   = (CLOG > 8) ? CLOG : 8;
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);
`else
   localparam int unsigned unused_timeout = TIMEOUT_CYCLES;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] instret_q, instret_d;
   logic [1:0]  cause_q, cause_d;
`ifdef FETCH_TIMEOUT_EN
   logic [CW-1:0] wcnt_q, wcnt_d;
`endif

   // Next-state and datapath updates for the fetch/execute handshake loop
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      instret_d = instret_q;
      cause_d   = cause_q;
`ifdef FETCH_TIMEOUT_EN
      wcnt_d    = wcnt_q;
`endif
      case (state_q)
         S_REQ: begin
            if (imem_req_ready_i) begin
               state_d = S_WAIT;
`ifdef FETCH_TIMEOUT_EN
               wcnt_d  = '0;
`endif
            end
         end
         S_WAIT: begin
            if (imem_resp_valid_i) begin
               if (imem_resp_err_i) begin
                  cause_d = CAUSE_BUS;
                  state_d = S_FAULT;
               end else begin
                  inst_d  = imem_resp_data_i;
                  state_d = S_EXEC;
               end
            end
`ifdef FETCH_TIMEOUT_EN
            else begin
               wcnt_d = wcnt_q + CW'(1);
               if (wcnt_d == TO_LIM) begin
                  cause_d = CAUSE_TIMEOUT;
                  state_d = S_FAULT;
               end
            end
`endif
         end
         S_EXEC: begin
            if (exec_done_i) begin
               instret_d = instret_q + 32'd1;
               if (halt_i) begin
                  state_d = S_HALT;
               end else if (npc_i[1:0] != 2'b00) begin
                  cause_d = CAUSE_MISALIGN;
                  state_d = S_FAULT;
               end else begin
                  pc_d    = npc_i;
                  state_d = S_REQ;
               end
            end
         end
         default: ;
      endcase
   end

   // State and architectural registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         inst_q    <= '0;
         instret_q <= '0;
         cause_q   <= '0;
`ifdef FETCH_TIMEOUT_EN
         wcnt_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         instret_q <= instret_d;
         cause_q   <= cause_d;
`ifdef FETCH_TIMEOUT_EN
         wcnt_q    <= wcnt_d;
`endif
      end
   end

   assign imem_req_valid_o = (state_q == S_REQ) && !rst;
   assign imem_req_addr_o  = pc_q;
   assign pc_o             = pc_q;
   assign inst_o           = inst_q;
   assign inst_valid_o     = (state_q == S_EXEC);
   assign retire_o         = (state_q == S_EXEC) && exec_done_i && !rst;
   assign instret_o        = instret_q;
   assign halted_o         = (state_q == S_HALT);
   assign fault_o          = (state_q == S_FAULT);
   assign fault_cause_o    = cause_q;

endmodule

// File: tb/tb_riscv_fetch_ctrl.sv
// Bench for riscv_fetch_ctrl: directed scenarios, a transaction-level
// reference model compared every cycle, and literal pins on key results.
module tb_riscv_fetch_ctrl;

`ifdef FETCH_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc_i;
   logic        exec_done_i, halt_i;
   logic        imem_req_valid_o, imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_resp_valid_i, imem_resp_err_i;
   logic [31:0] imem_resp_data_i;
   logic [31:0] pc_o, inst_o, instret_o;
   logic        inst_valid_o, retire_o, halted_o, fault_o;
   logic [1:0]  fault_cause_o;

   always #5 clk = ~clk;

   riscv_fetch_ctrl #(
      .RESET_PC(32'h0000_0000),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .npc_i(npc_i),
      .exec_done_i(exec_done_i),
      .halt_i(halt_i),
      .imem_req_valid_o(imem_req_valid_o),
      .imem_req_ready_i(imem_req_ready_i),
      .imem_req_addr_o(imem_req_addr_o),
      .imem_resp_valid_i(imem_resp_valid_i),
      .imem_resp_data_i(imem_resp_data_i),
      .imem_resp_err_i(imem_resp_err_i),
      .pc_o(pc_o),
      .inst_o(inst_o),
      .inst_valid_o(inst_valid_o),
      .retire_o(retire_o),
      .instret_o(instret_o),
      .halted_o(halted_o),
      .fault_o(fault_o),
      .fault_cause_o(fault_cause_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Environment knobs set by the stimulus
   bit ready_en, resp_en, resp_err, done_en, halt_at4;
   int npc_mode;

   bit          pending;
   logic [31:0] acc_q[$];
   int          ret_cnt;

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_q.size()) return acc_q[i];
      return 32'hFFFF_FFFF;
   endfunction

   // Memory side: remember accepted requests, answer one cycle later
   always @(posedge clk) begin
      if (rst) begin
         pending <= 1'b0;
      end else begin
         if (imem_resp_valid_i) pending <= 1'b0;
         if (imem_req_valid_o && imem_req_ready_i) begin
            pending <= 1'b1;
            acc_q.push_back(imem_req_addr_o);
         end
      end
   end

   // Drive environment inputs mid-cycle from the knobs
   always @(negedge clk) begin
      #2;
      imem_req_ready_i  = ready_en;
      imem_resp_valid_i = pending && resp_en;
      imem_resp_err_i   = resp_err;
      imem_resp_data_i  = {imem_req_addr_o[15:0], 16'h0013};
      exec_done_i       = done_en;
      halt_i            = halt_at4 && (pc_o == 32'h4);
      if (npc_mode == 1)
         npc_i = (pc_o == 32'h0) ? 32'h100 : 32'h102;
      else
         npc_i = pc_o + 32'd4;
   end

   // Reference model: an instruction is fetched, awaited, then retired
   bit          m_live = 1'b0;
   bit          m_halt, m_fault;
   int          m_phase;
   int          m_wait;
   logic [31:0] m_pc, m_inst, m_instret;
   logic [1:0]  m_cause;

   always @(posedge clk) begin
      if (rst) begin
         m_live    <= 1'b1;
         m_halt    <= 1'b0;
         m_fault   <= 1'b0;
         m_phase   <= 0;
         m_wait    <= 0;
         m_pc      <= 32'h0;
         m_inst    <= 32'h0;
         m_instret <= 32'h0;
         m_cause   <= 2'b00;
      end else if (m_live && !m_halt && !m_fault) begin
         if (m_phase == 0) begin
            if (imem_req_ready_i) begin
               m_phase <= 1;
               m_wait  <= 0;
            end
         end else if (m_phase == 1) begin
            if (imem_resp_valid_i) begin
               if (imem_resp_err_i) begin
                  m_cause <= 2'b10;
                  m_fault <= 1'b1;
               end else begin
                  m_inst  <= imem_resp_data_i;
                  m_phase <= 2;
               end
            end else begin
               m_wait <= m_wait + 1;
`ifdef FETCH_TIMEOUT_EN
               if (m_wait + 1 >= TO) begin
                  m_cause <= 2'b11;
                  m_fault <= 1'b1;
               end
`endif
            end
         end else if (exec_done_i) begin
            m_instret <= m_instret + 32'd1;
            if (halt_i) begin
               m_halt <= 1'b1;
            end else if (npc_i % 4 != 0) begin
               m_cause <= 2'b01;
               m_fault <= 1'b1;
            end else begin
               m_pc    <= npc_i;
               m_phase <= 0;
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (m_live) begin
         automatic bit run = !m_halt && !m_fault;
         chk("req_valid", imem_req_valid_o, !rst && run && m_phase == 0);
         chk("req_addr", imem_req_addr_o, m_pc);
         chk("pc", pc_o, m_pc);
         chk("inst", inst_o, m_inst);
         chk("inst_valid", inst_valid_o, run && m_phase == 2);
         chk("retire", retire_o,
             !rst && run && m_phase == 2 && exec_done_i);
         chk("instret", instret_o, m_instret);
         chk("halted", halted_o, m_halt);
         chk("fault", fault_o, m_fault);
         chk("cause", fault_cause_o, m_cause);
         if (retire_o) ret_cnt++;
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      acc_q.delete();
   endtask

   initial begin
      rst = 1'b1;
      ready_en = 0; resp_en = 0; resp_err = 0;
      done_en = 0; halt_at4 = 0; npc_mode = 0;
      npc_i = 0; exec_done_i = 0; halt_i = 0;
      imem_req_ready_i = 0; imem_resp_valid_i = 0;
      imem_resp_err_i = 0; imem_resp_data_i = 0;
      ret_cnt = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_pc", pc_o, 32'h0);
      chk("rst_instret", instret_o, 32'h0);
      chk("rst_req_valid", imem_req_valid_o, 1'b0);
      chk("rst_fault", fault_o, 1'b0);
      chk("rst_halted", halted_o, 1'b0);
      chk("rst_cause", fault_cause_o, 2'b00);

      // Straight-line fetch: 3 cycles per instruction
      ready_en = 1; resp_en = 1; done_en = 1; npc_mode = 0;
      #1 rst = 1'b0;
      acc_q.delete();
      #1;
      chk("first_req_valid", imem_req_valid_o, 1'b1);
      chk("first_req_addr", imem_req_addr_o, 32'h0);
      repeat (9) @(negedge clk);
      chk("seq_instret", instret_o, 32'd3);
      chk("seq_pc", pc_o, 32'hC);
      chk("seq_nreq", acc_q.size(), 32'd3);
      chk("seq_addr0", acc_at(0), 32'h0);
      chk("seq_addr1", acc_at(1), 32'h4);
      chk("seq_addr2", acc_at(2), 32'h8);

      // Request backpressure, then execute held off
      ready_en = 0; done_en = 0;
      reset_dut();
      repeat (4) begin
         @(negedge clk);
         chk("bp_valid", imem_req_valid_o, 1'b1);
         chk("bp_addr", imem_req_addr_o, 32'h0);
      end
      #1 ready_en = 1;
      @(negedge clk);
      chk("bp_wait_valid", imem_req_valid_o, 1'b0);
      chk("bp_nreq", acc_q.size(), 32'd1);
      @(negedge clk);
      chk("bp_inst_valid", inst_valid_o, 1'b1);
      chk("bp_inst", inst_o, 32'h0000_0013);
      repeat (3) @(negedge clk);
      chk("bp_hold_valid", inst_valid_o, 1'b1);
      chk("bp_instret", instret_o, 32'd0);

      // Taken branch then misaligned target
      done_en = 1; npc_mode = 1;
      reset_dut();
      repeat (12) @(negedge clk);
      chk("br_nreq", acc_q.size(), 32'd2);
      chk("br_addr1", acc_at(1), 32'h100);
      chk("br_fault", fault_o, 1'b1);
      chk("br_cause", fault_cause_o, 2'b01);
      chk("br_pc", pc_o, 32'h100);
      chk("br_instret", instret_o, 32'd2);
      chk("br_no_req", imem_req_valid_o, 1'b0);

      // Bus error on the first response
      npc_mode = 0; resp_err = 1;
      reset_dut();
      repeat (4) @(negedge clk);
      chk("be_fault", fault_o, 1'b1);
      chk("be_cause", fault_cause_o, 2'b10);
      chk("be_instret", instret_o, 32'd0);
      chk("be_nreq", acc_q.size(), 32'd1);
      resp_err = 0;

      // ebreak at 0x4, then reset resumes fetching
      halt_at4 = 1;
      reset_dut();
      ret_cnt = 0;
      repeat (12) @(negedge clk);
      chk("ht_halted", halted_o, 1'b1);
      chk("ht_pc", pc_o, 32'h4);
      chk("ht_retires", ret_cnt, 32'd2);
      chk("ht_instret", instret_o, 32'd2);
      chk("ht_no_req", imem_req_valid_o, 1'b0);
      chk("ht_inst_valid", inst_valid_o, 1'b0);
      halt_at4 = 0;
      reset_dut();
      #1;
      chk("ht_rst_pc", pc_o, 32'h0);
      chk("ht_rst_req", imem_req_valid_o, 1'b1);
      repeat (3) @(negedge clk);
      chk("ht_resume_instret", instret_o, 32'd1);
      chk("ht_resume_nreq", acc_q.size(), 32'd1);

      // No response ever arrives
      resp_en = 0; done_en = 0;
      reset_dut();
`ifdef FETCH_TIMEOUT_EN
      repeat (4) @(negedge clk);
      chk("to_before", fault_o, 1'b0);
      @(negedge clk);
      chk("to_fault", fault_o, 1'b1);
      chk("to_cause", fault_cause_o, 2'b11);
`else
      repeat (1000) @(negedge clk);
      chk("nto_fault", fault_o, 1'b0);
      chk("nto_req", imem_req_valid_o, 1'b0);
      chk("nto_inst_valid", inst_valid_o, 1'b0);
`endif
      chk("to_nreq", acc_q.size(), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
